// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-operand accumulator sequencer with ripple-carry final resolution.
// Optional build macro: CSA_SATURATE_EN clamps an overflowed result to all-ones.

module ripple_adder #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[W];
endmodule

// state   | meaning
// IDLE    | waiting for first operand of a group
// ACCUM   | folding operands into the S/C pair
// RESOLVE | S/C frozen, ripple adder settling
// DONE    | result presented, waiting for out_ready
module csa_accum_ctrl #(
  parameter int N              = 8,
  parameter int G              = 4,
  parameter int RESOLVE_CYCLES = 2,
  parameter int CW             = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+G-1:0]   out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic [CW-1:0]    op_count
);
  localparam int W   = N + G;
  localparam int RCW = (RESOLVE_CYCLES > 1) ? $clog2(RESOLVE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t         state;
  logic [W-1:0]   acc_s;
  logic [W-1:0]   acc_c;
  logic           ovf;
  logic [RCW-1:0] res_cnt;
  logic           res_entry;

  logic [W-1:0]   x;
  logic [W-1:0]   s_base;
  logic [W-1:0]   c_base;
  logic [W-1:0]   maj;
  logic [W-1:0]   step_s;
  logic [W-1:0]   step_c;
  logic           step_ovf;
  logic [CW-1:0]  cnt_next;
  logic [W-1:0]   rip_s;
  logic           rip_cout;
  logic           fin_ovf;
  logic [W-1:0]   fin_sum;
  logic           accept;

  assign accept = in_valid & in_ready;

  // A group starting in IDLE folds its first operand into a cleared S/C pair.
  always_comb begin
    x        = {{G{1'b0}}, in_data};
    s_base   = (state == IDLE) ? '0 : acc_s;
    c_base   = (state == IDLE) ? '0 : acc_c;
    maj      = (s_base & c_base) | (s_base & x) | (c_base & x);
    step_s   = s_base ^ c_base ^ x;
    step_c   = {maj[W-2:0], 1'b0};
    step_ovf = maj[W-1] | ((state != IDLE) & ovf);
    if (state == IDLE)
      cnt_next = CW'(1);
    else if (op_count == '1)
      cnt_next = op_count;
    else
      cnt_next = op_count + CW'(1);
  end

  ripple_adder #(.W(W)) u_ripple (
    .a    (acc_s),
    .b    (acc_c),
    .cin  (1'b0),
    .s    (rip_s),
    .cout (rip_cout)
  );

  always_comb begin
    fin_ovf = ovf | rip_cout;
`ifdef CSA_SATURATE_EN
    fin_sum = fin_ovf ? '1 : rip_s;
`else
    fin_sum = rip_s;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_s     <= '0;
      acc_c     <= '0;
      ovf       <= 1'b0;
      res_cnt   <= '0;
      res_entry <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      op_count  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_s    <= step_s;
            acc_c    <= step_c;
            ovf      <= step_ovf;
            op_count <= cnt_next;
            busy     <= 1'b1;
            if (in_last) begin
              state     <= RESOLVE;
              in_ready  <= 1'b0;
              res_entry <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          // First RESOLVE cycle arms the settle timer; capture on terminal count.
          if (res_entry) begin
            res_entry <= 1'b0;
            res_cnt   <= RCW'(RESOLVE_CYCLES - 1);
          end else if (res_cnt == '0) begin
            out_sum   <= fin_sum;
            out_ovf   <= fin_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            res_cnt <= res_cnt - RCW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
